// File: rtl/arcfour_pkg.sv
// Shared types and constants for the ARCFOUR key-scheduling engine.
// The debug taps are enabled by defining ARCFOUR_TAPS_EN.
package arcfour_pkg;

    localparam int S_DEPTH           = 256;
    localparam int KEY_BYTES_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        READ_SI  = 3'd2,
        CALC_J   = 3'd3,
        READ_SJ  = 3'd4,
        WRITE_SI = 3'd5,
        WRITE_SJ = 3'd6,
        DONE     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_FILL    = 2'd1,
        PH_SHUFFLE = 2'd2,
        PH_DONE    = 2'd3
    } phase_t;

    function automatic phase_t phase_of(input state_t s);
        case (s)
            IDLE:    return PH_IDLE;
            FILL:    return PH_FILL;
            DONE:    return PH_DONE;
            default: return PH_SHUFFLE;
        endcase
    endfunction

endpackage

// File: rtl/arcfour_key_sel.sv
// Selects one key byte by index; byte 0 is the most significant byte of the key.
module arcfour_key_sel
    import arcfour_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
    parameter int SEL_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [SEL_W-1:0]       sel,
    output logic [7:0]             key_byte
);

    always_comb begin
        key_byte = '0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (sel == SEL_W'(n)) begin
                key_byte = key[8*(KEY_BYTES-n)-1 -: 8];
            end
        end
    end

endmodule

// File: rtl/arcfour.sv
// RC4 key-scheduling engine driving an external 256x8 synchronous RAM.
// Define ARCFOUR_TAPS_EN to drive the debug tap ports; otherwise they read 0.
module arcfour
    import arcfour_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic                   start_sig,
    output logic                   arcfour_finished,
    input  logic [7:0]             ram_out,
    output logic                   write_enable,
    output logic [7:0]             ram_in,
    output logic [7:0]             address,
    output logic [2:0]             state_tap,
    output logic [1:0]             fTap,
    output logic [7:0]             iTap,
    output logic [7:0]             jTap,
    output logic [7:0]             siTap,
    output logic [7:0]             sjTap,
    output logic                   readTap,
    output logic                   writeTap
);

    localparam int               SEL_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [7:0]       LAST      = 8'(S_DEPTH - 1);
    localparam logic [SEL_W-1:0] KSEL_LAST = SEL_W'(KEY_BYTES - 1);

    state_t           state;
    logic [7:0]       i;
    logic [7:0]       j;
    logic [7:0]       si;
    logic [SEL_W-1:0] ksel;
    logic [7:0]       key_byte;
    logic [7:0]       j_next;

    arcfour_key_sel #(
        .KEY_BYTES(KEY_BYTES),
        .SEL_W    (SEL_W)
    ) u_key_sel (
        .key     (key),
        .sel     (ksel),
        .key_byte(key_byte)
    );

    assign j_next = j + ram_out + key_byte;

    // Outputs are loaded on the edge that enters each state, so RAM sees them for that whole state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            i                <= '0;
            j                <= '0;
            si               <= '0;
            ksel             <= '0;
            address          <= '0;
            ram_in           <= '0;
            write_enable     <= 1'b0;
            arcfour_finished <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_sig) begin
                        state        <= FILL;
                        i            <= '0;
                        address      <= '0;
                        ram_in       <= '0;
                        write_enable <= 1'b1;
                    end
                end
                FILL: begin
                    if (i == LAST) begin
                        state        <= READ_SI;
                        i            <= '0;
                        j            <= '0;
                        ksel         <= '0;
                        address      <= '0;
                        write_enable <= 1'b0;
                    end else begin
                        i       <= i + 8'd1;
                        address <= i + 8'd1;
                        ram_in  <= i + 8'd1;
                    end
                end
                READ_SI: begin
                    state <= CALC_J;
                end
                CALC_J: begin
                    si      <= ram_out;
                    j       <= j_next;
                    address <= j_next;
                    state   <= READ_SJ;
                end
                READ_SJ: begin
                    ram_in       <= si;
                    write_enable <= 1'b1;
                    state        <= WRITE_SI;
                end
                // S[j] was read before either write, so i == j still stores the original S[i] twice.
                WRITE_SI: begin
                    address <= i;
                    ram_in  <= ram_out;
                    state   <= WRITE_SJ;
                end
                WRITE_SJ: begin
                    write_enable <= 1'b0;
                    i            <= i + 8'd1;
                    ksel         <= (ksel == KSEL_LAST) ? '0 : ksel + 1'b1;
                    if (i == LAST) begin
                        state            <= DONE;
                        arcfour_finished <= 1'b1;
                        address          <= '0;
                        ram_in           <= '0;
                    end else begin
                        address <= i + 8'd1;
                        state   <= READ_SI;
                    end
                end
                DONE: begin
                    if (!start_sig) begin
                        state            <= IDLE;
                        arcfour_finished <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef ARCFOUR_TAPS_EN
    logic [7:0] sj;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sj <= '0;
        end else if (state == WRITE_SI) begin
            sj <= ram_out;
        end
    end

    assign state_tap = state;
    assign fTap      = phase_of(state);
    assign iTap      = i;
    assign jTap      = j;
    assign siTap     = si;
    assign sjTap     = sj;
    assign readTap   = (state == READ_SI) || (state == READ_SJ);
    assign writeTap  = write_enable;
`else
    assign state_tap = '0;
    assign fTap      = '0;
    assign iTap      = '0;
    assign jTap      = '0;
    assign siTap     = '0;
    assign sjTap     = '0;
    assign readTap   = 1'b0;
    assign writeTap  = 1'b0;
`endif

endmodule

// File: tb/tb_arcfour.sv
// Self-checking bench for arcfour: an S RAM model plus a write scoreboard fed by a software KSA.
// Tap checks follow ARCFOUR_TAPS_EN (driven values when defined, zeros otherwise).
module tb_arcfour;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] key = '0;
    logic        start_sig = 1'b0;
    logic        arcfour_finished;
    logic [7:0]  ram_out;
    logic        write_enable;
    logic [7:0]  ram_in;
    logic [7:0]  address;
    logic [2:0]  state_tap;
    logic [1:0]  fTap;
    logic [7:0]  iTap, jTap, siTap, sjTap;
    logic        readTap, writeTap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] model_s [256];
    logic [7:0] mem [256];

    arcfour dut (
        .clk             (clk),
        .reset           (reset),
        .key             (key),
        .start_sig       (start_sig),
        .arcfour_finished(arcfour_finished),
        .ram_out         (ram_out),
        .write_enable    (write_enable),
        .ram_in          (ram_in),
        .address         (address),
        .state_tap       (state_tap),
        .fTap            (fTap),
        .iTap            (iTap),
        .jTap            (jTap),
        .siTap           (siTap),
        .sjTap           (sjTap),
        .readTap         (readTap),
        .writeTap        (writeTap)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with read-old-data behaviour.
    always @(posedge clk) begin
        if (write_enable) mem[address] <= ram_in;
        ram_out <= mem[address];
    end

    function automatic logic [7:0] key_byte_of(input logic [23:0] k, input int n);
        case (n)
            0:       return k[23:16];
            1:       return k[15:8];
            default: return k[7:0];
        endcase
    endfunction

    task automatic build_expected(input logic [23:0] k);
        wr_t        w;
        logic [7:0] jj, a, b;
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            w.addr = 8'(n);
            w.data = 8'(n);
            exp_q.push_back(w);
            model_s[n] = 8'(n);
        end
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            jj = jj + model_s[n] + key_byte_of(k, n % 3);
            a = model_s[n];
            b = model_s[jj];
            w.addr = jj;
            w.data = a;
            exp_q.push_back(w);
            w.addr = 8'(n);
            w.data = b;
            exp_q.push_back(w);
            model_s[n]  = b;
            model_s[jj] = a;
        end
    endtask

    task automatic run_ksa(input logic [23:0] k, input bit hold, input bit early, input string tag);
        wr_t        e;
        int         n = -1;
        int         wr_idx = 0;
        bit         done = 0;
        int         bad = 0;
        logic [7:0] obs_a [8];
        logic [7:0] obs_d [8];
        logic [7:0] ref_a [8];
        logic [7:0] ref_d [8];
        ref_a = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd5, 8'd3};
        ref_d = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd2, 8'd5};
        key = k;
        build_expected(k);
        @(negedge clk);
        start_sig = 1'b1;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (n >= 0) n++;
            else if (write_enable) n = 0;
            if (!hold && n >= 0) start_sig = 1'b0;
            if (write_enable) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s extra_write #%0d: got addr=%0d data=%0d, expected no write", tag, wr_idx, address, ram_in);
                end else begin
                    e = exp_q.pop_front();
                    if (address !== e.addr || ram_in !== e.data) begin
                        errors++;
                        $display("[TB] FAIL %s write #%0d: got addr=%0d data=%0d, expected addr=%0d data=%0d", tag, wr_idx, address, ram_in, e.addr, e.data);
                    end
                end
                if (wr_idx >= 256 && wr_idx < 264) begin
                    obs_a[wr_idx-256] = address;
                    obs_d[wr_idx-256] = ram_in;
                end
`ifdef ARCFOUR_TAPS_EN
                if (wr_idx == 10 || wr_idx == 300) begin
                    checks++;
                    if (fTap !== ((wr_idx < 256) ? 2'd1 : 2'd2) || writeTap !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL %s phase_tap: got fTap=%0d writeTap=%0b, expected fTap=%0d writeTap=1", tag, fTap, writeTap, (wr_idx < 256) ? 1 : 2);
                    end
                end
                if (early && wr_idx == 260) begin
                    checks++;
                    if (iTap !== 8'd2 || jTap !== 8'd3 || siTap !== 8'd2) begin
                        errors++;
                        $display("[TB] FAIL %s i2_taps: got i=%0d j=%0d si=%0d, expected i=2 j=3 si=2", tag, iTap, jTap, siTap);
                    end
                end
                if (early && wr_idx == 261) begin
                    checks++;
                    if (sjTap !== 8'd3) begin
                        errors++;
                        $display("[TB] FAIL %s i2_sj_tap: got %0d, expected 3", tag, sjTap);
                    end
                end
`else
                if (wr_idx == 300) begin
                    checks++;
                    if ({state_tap, fTap, iTap, jTap, siTap, sjTap, readTap, writeTap} !== '0) begin
                        errors++;
                        $display("[TB] FAIL %s taps_tied: got nonzero tap (state=%0d f=%0d i=%0d), expected 0", tag, state_tap, fTap, iTap);
                    end
                end
`endif
                wr_idx++;
            end
            if (arcfour_finished) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s finish_timeout: got finished=0 after 2000 cycles, expected 1", tag);
        end else if (n != 1536) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d cycles, expected 1536", tag, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s missing_writes: got %0d left, expected 0", tag, exp_q.size());
        end
        for (int a = 0; a < 256; a++) if (mem[a] !== model_s[a]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL %s final_s: got %0d wrong entries, expected 0", tag, bad);
        end
        if (early) begin
            for (int w = 0; w < 8; w++) begin
                checks++;
                if (obs_a[w] !== ref_a[w] || obs_d[w] !== ref_d[w]) begin
                    errors++;
                    $display("[TB] FAIL %s early_swap #%0d: got addr=%0d data=%0d, expected addr=%0d data=%0d", tag, w, obs_a[w], obs_d[w], ref_a[w], ref_d[w]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_sig = 1'b0;
        #150;
        checks++;
        if ({arcfour_finished, write_enable, ram_in, address, state_tap} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got fin=%0b we=%0b din=%0d addr=%0d state=%0d, expected all 0", arcfour_finished, write_enable, ram_in, address, state_tap);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({arcfour_finished, write_enable, ram_in, address, state_tap, fTap, iTap, jTap, siTap, sjTap, readTap, writeTap} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_idle: got fin=%0b we=%0b addr=%0d state=%0d, expected all 0", arcfour_finished, write_enable, address, state_tap);
            end
        end
    endtask

    task automatic test_fill_shuffle();
        run_ksa(24'h000000, 1'b0, 1'b1, "key0");
    endtask

    task automatic test_key_0102ff();
        run_ksa(24'h0102FF, 1'b0, 1'b0, "key0102ff");
    endtask

    task automatic test_back_to_back();
        run_ksa(24'hA55A3C, 1'b1, 1'b0, "hold");
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (arcfour_finished !== 1'b1 || write_enable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL done_hold: got fin=%0b we=%0b, expected fin=1 we=0", arcfour_finished, write_enable);
            end
        end
        start_sig = 1'b0;
        @(negedge clk);
        checks++;
        if (arcfour_finished !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_release: got fin=%0b, expected 0", arcfour_finished);
        end
`ifdef ARCFOUR_TAPS_EN
        checks++;
        if (state_tap !== 3'd0) begin
            errors++;
            $display("[TB] FAIL done_release_state: got %0d, expected 0", state_tap);
        end
`endif
        start_sig = 1'b1;
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b1 || address !== 8'd0 || ram_in !== 8'd0) begin
            errors++;
            $display("[TB] FAIL restart_fill: got we=%0b addr=%0d data=%0d, expected we=1 addr=0 data=0", write_enable, address, ram_in);
        end
        start_sig = 1'b0;
    endtask

    task automatic test_abort();
        int wr = 0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        key = 24'h0102FF;
        @(negedge clk);
        start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        if (write_enable) wr++;
        for (int cyc = 0; cyc < 1200 && wr < 456; cyc++) begin
            @(negedge clk);
            if (write_enable) wr++;
        end
        checks++;
        if (wr < 456) begin
            errors++;
            $display("[TB] FAIL abort_reach: got %0d writes, expected 456", wr);
        end
`ifdef ARCFOUR_TAPS_EN
        checks++;
        if (fTap !== 2'd2) begin
            errors++;
            $display("[TB] FAIL abort_phase: got fTap=%0d, expected 2", fTap);
        end
`endif
        #2 reset = 1'b0;
        #1;
        checks++;
        if (arcfour_finished !== 1'b0 || write_enable !== 1'b0 || address !== 8'd0 || state_tap !== 3'd0) begin
            errors++;
            $display("[TB] FAIL abort_reset: got fin=%0b we=%0b addr=%0d state=%0d, expected all 0", arcfour_finished, write_enable, address, state_tap);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (write_enable !== 1'b0 || arcfour_finished !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got we=%0b fin=%0b, expected 0 0", write_enable, arcfour_finished);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'hEE;
        test_reset();
        test_fill_shuffle();
        test_key_0102ff();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
